bcd_to_bin: RTL

Sequential multi-digit packed-BCD to unsigned-binary converter. It is the decode direction of the datapath's BCD arithmetic: it turns BCD results, such as a chain of BCD digit adders, back into binary for downstream compute. It processes one digit per cycle, MSD first, using multiply-by-ten accumulate. Input and output each use a valid/ready handshake. Digits greater than 9 are flagged.

---
 rtl/bcd_to_bin.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
//   Sequential packed-BCD to unsigned-binary converter. One digit is consumed
//   per clock, most significant digit first, using acc = acc*10 + digit.
//   A word containing any digit above 9 is not converted; it completes on the
//   following cycle with out_error set and out_bin cleared.
//
// Parameters
//   DIGITS : number of BCD digits in in_bcd (1..8)
//   BIN_W  : binary result width; 2**BIN_W must exceed 10**DIGITS - 1
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   in_bcd is valid
//   in_ready  out  converter idle and able to accept (forced low during rst)
//   in_bcd    in   packed BCD word, digit 0 = [3:0] = least significant
//   out_valid out  result available (registered)
//   out_ready in   consumer takes the result
//   abort     in   (BCD_TO_BIN_ABORT_EN only) drop the conversion in progress
//   out_bin   out  binary result (registered, held until next completion)
//   out_error out  at least one input digit was above 9 (registered)
//
// Configuration
//   BCD_TO_BIN_ABORT_EN : when defined, adds the abort input. Abort returns
//   the block to IDLE from CONV or DONE without producing a result, and in
//   IDLE it blocks acceptance.
// -----------------------------------------------------------------------------
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef BCD_TO_BIN_ABORT_EN
  input  logic                  abort,
`endif
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_error
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [4*DIGITS-1:0]   r_shift;
  logic [BIN_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIN_W-1:0]      r_out_bin;
  logic                  r_out_error;
  logic                  r_out_valid;

  logic [4*DIGITS-1:0]   w_shift_nxt;
  logic [BIN_W-1:0]      w_acc_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [BIN_W-1:0]      w_bin_nxt;
  logic                  w_err_nxt;

  logic                  w_abort;
  logic                  w_accept;
  logic                  w_bad_digit;
  logic                  w_last_digit;
  logic [3:0]            w_msd;
  logic [BIN_W-1:0]      w_acc_step;

  // True when any 4-bit digit of the word is in the range A..F.
  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (word[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

`ifdef BCD_TO_BIN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign in_ready     = (r_state == S_IDLE) && !rst;
  // Abort wins over a simultaneous accept.
  assign w_accept     = in_valid && in_ready && !w_abort;
  assign w_bad_digit  = has_bad_digit(in_bcd);
  assign w_last_digit = (r_cnt == CNT_W'(DIGITS - 1));
  assign w_msd        = r_shift[4*DIGITS-1 -: 4];
  // acc*10 as shift-and-add, truncated to BIN_W.
  assign w_acc_step   = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_msd);

  assign out_valid = r_out_valid;
  assign out_bin   = r_out_bin;
  assign out_error = r_out_error;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_bad_digit ? S_DONE : S_CONV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONV: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last_digit) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CONV;
        end
      end
      S_DONE: begin
        if (w_abort || out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and result next values for the current state.
  always_comb begin
    w_shift_nxt = r_shift;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_bin_nxt   = r_out_bin;
    w_err_nxt   = r_out_error;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = in_bcd;
          w_acc_nxt   = {BIN_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
          if (w_bad_digit) begin
            w_bin_nxt = {BIN_W{1'b0}};
            w_err_nxt = 1'b1;
          end else begin
            w_bin_nxt = r_out_bin;
            w_err_nxt = r_out_error;
          end
        end else begin
          w_shift_nxt = r_shift;
        end
      end
      S_CONV: begin
        if (w_abort) begin
          w_shift_nxt = r_shift;
        end else begin
          w_acc_nxt   = w_acc_step;
          w_shift_nxt = r_shift << 4;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (w_last_digit) begin
            w_bin_nxt = w_acc_step;
            w_err_nxt = 1'b0;
          end else begin
            w_bin_nxt = r_out_bin;
          end
        end
      end
      S_DONE: begin
        w_shift_nxt = r_shift;
      end
      default: begin
        w_shift_nxt = r_shift;
      end
    endcase
  end

  // Datapath and registered outputs; out_valid tracks entry into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= {(4*DIGITS){1'b0}};
      r_acc       <= {BIN_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_out_bin   <= {BIN_W{1'b0}};
      r_out_error <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_bin   <= w_bin_nxt;
      r_out_error <= w_err_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

endmodule
